// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State enum, opcode/funct constants, control field codes, trap causes.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_J  = 3'd4;

  localparam logic [4:0] BR_JUMP = 5'b01111;
  localparam logic [4:0] BR_NONE = 5'b10101;
  localparam logic [4:0] ALU_ADD = 5'b00000;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       alua_src;
    logic       alub_src;
    logic [4:0] br_op;
    logic [4:0] alu_op;
    logic [2:0] dm_ctrl;
    logic [1:0] wb_src;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
  } ctrl_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational RV32I(+M) decoder: opcode/funct fields to control bundle.
// Flags any encoding outside the supported subset as illegal.
module mc_decoder
  import cu_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  // Decode one instruction into its control bundle and legality flag
  always_comb begin
    ctrl_o       = '0;
    ctrl_o.br_op = BR_NONE;
    illegal_o    = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_R): begin
        ctrl_o.alu_op = {funct7_i == F7_M, funct7_i[5], funct3_i};
        illegal_o = !((funct7_i == F7_BASE) ||
                      ((funct7_i == F7_ALT) &&
                       (funct3_i == 3'b000 || funct3_i == 3'b101)) ||
                      ((funct7_i == F7_M) && SUPPORT_M));
      end
      (opcode_i == OP_IMM): begin
        ctrl_o.alub_src = 1'b1;
        ctrl_o.alu_op = {1'b0,
                         (funct3_i == 3'b101) && funct7_i[5],
                         funct3_i};
        illegal_o = ((funct3_i == 3'b001) && (funct7_i != F7_BASE)) ||
                    ((funct3_i == 3'b101) && (funct7_i != F7_BASE) &&
                     (funct7_i != F7_ALT));
      end
      (opcode_i == OP_LOAD): begin
        ctrl_o.alub_src = 1'b1;
        ctrl_o.dm_ctrl  = funct3_i;
        ctrl_o.wb_src   = WB_DM;
        ctrl_o.is_load  = 1'b1;
        illegal_o = funct3_i inside {3'b011, 3'b110, 3'b111};
      end
      (opcode_i == OP_STORE): begin
        ctrl_o.imm_src  = IMM_SB;
        ctrl_o.alub_src = 1'b1;
        ctrl_o.dm_ctrl  = funct3_i;
        ctrl_o.is_store = 1'b1;
        illegal_o = funct3_i[2] || (funct3_i == 3'b011);
      end
      (opcode_i == OP_BRANCH): begin
        ctrl_o.imm_src   = IMM_SB;
        ctrl_o.alua_src  = 1'b1;
        ctrl_o.alub_src  = 1'b1;
        ctrl_o.br_op     = {2'b00, funct3_i};
        ctrl_o.is_branch = 1'b1;
        illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      (opcode_i == OP_JAL): begin
        ctrl_o.imm_src  = IMM_J;
        ctrl_o.alua_src = 1'b1;
        ctrl_o.alub_src = 1'b1;
        ctrl_o.br_op    = BR_JUMP;
        ctrl_o.wb_src   = WB_PC4;
      end
      (opcode_i == OP_JALR): begin
        ctrl_o.alub_src = 1'b1;
        ctrl_o.br_op    = BR_JUMP;
        ctrl_o.wb_src   = WB_PC4;
        illegal_o = (funct3_i != 3'b000);
      end
      (opcode_i == OP_LUI): begin
        ctrl_o.imm_src  = IMM_U;
        ctrl_o.alub_src = 1'b1;
        ctrl_o.alu_op   = ALU_ADD;
      end
      (opcode_i == OP_AUIPC): begin
        ctrl_o.imm_src  = IMM_U;
        ctrl_o.alua_src = 1'b1;
        ctrl_o.alub_src = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback.
// Handles memory ready waits, wait timeouts and illegal-instruction traps.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter bit          SUPPORT_M   = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       IMReady,
  input  logic       DMReady,
  input  logic       TrapAck,
  output logic       IMReq,
  output logic       IRWr,
  output logic       PCWr,
  output logic       RUWr,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [4:0] BrOp,
  output logic [4:0] ALUOp,
  output logic       DMReq,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [1:0] RUDataWrSrc,
  output logic       Trap,
  output logic [1:0] TrapCause,
  output logic [2:0] State
);

  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam int unsigned CW =
    TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         dec_ctrl;
  logic          dec_illegal;
  logic          timeout_hit;
  logic          fields_on;

  mc_decoder #(
    .SUPPORT_M(SUPPORT_M)
  ) u_dec (
    .opcode_i (Opcode),
    .funct3_i (Funct3),
    .funct7_i (Funct7),
    .ctrl_o   (dec_ctrl),
    .illegal_o(dec_illegal)
  );

  assign timeout_hit = TO_EN && (cnt_q == CNT_MAX);

  // State, field and trap-cause registers; reset aborts instantly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state enables
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cause_d = cause_q;
    IMReq   = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RUWr    = 1'b0;
    DMReq   = 1'b0;
    DMWr    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IMReq = 1'b1;
        if (IMReady) begin
          IRWr    = rst_n;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl;
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (ctrl_q.is_branch) begin
          PCWr    = 1'b1;
          state_d = S_FETCH;
        end else if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        DMReq = 1'b1;
        DMWr  = ctrl_q.is_store;
        if (DMReady) begin
          if (ctrl_q.is_store) begin
            PCWr    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: begin
        RUWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        if (TrapAck) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter: runs only while parked in FETCH or MEMORY
  always_comb begin
    cnt_d = '0;
    if (TO_EN && (state_d == state_q) &&
        (state_q == S_FETCH || state_q == S_MEMORY))
      cnt_d = cnt_q + CW'(1);
  end

  assign fields_on = (state_q == S_EXECUTE) ||
                     (state_q == S_MEMORY) ||
                     (state_q == S_WRITEBACK);

  assign ImmSrc      = fields_on ? ctrl_q.imm_src  : 3'd0;
  assign ALUASrc     = fields_on ? ctrl_q.alua_src : 1'b0;
  assign ALUBSrc     = fields_on ? ctrl_q.alub_src : 1'b0;
  assign BrOp        = fields_on ? ctrl_q.br_op    : 5'd0;
  assign ALUOp       = fields_on ? ctrl_q.alu_op   : 5'd0;
  assign DMCtrl      = fields_on ? ctrl_q.dm_ctrl  : 3'd0;
  assign RUDataWrSrc = fields_on ? ctrl_q.wb_src   : 2'd0;

  assign Trap      = (state_q == S_TRAP);
  assign TrapCause = cause_q;
  assign State     = state_q;

endmodule
